// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace-debug packet decoder.
package trdb_pkg;

  localparam int TRDB_LEN_W = 6;

  typedef enum logic [1:0] {
    TRDB_FMT0 = 2'd0,
    TRDB_FMT1 = 2'd1,
    TRDB_FMT2 = 2'd2,
    TRDB_FMT3 = 2'd3
  } trdb_format_e;

  typedef enum logic [1:0] {
    TRDB_SUB0 = 2'd0,
    TRDB_SUB1 = 2'd1,
    TRDB_SUB2 = 2'd2,
    TRDB_SUB3 = 2'd3
  } trdb_subformat_e;

endpackage

// File: rtl/trdb_packet_decoder.sv
// Frames a length-prefixed trace byte stream into packets and decodes the header fields.
// packet_valid_o rises one cycle after the last payload byte; ready_o is low while a packet waits.
module trdb_packet_decoder
  import trdb_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [7:0]               data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     packet_valid_o,
  input  logic                     packet_ready_i,
  output trdb_format_e             packet_format_o,
  output trdb_subformat_e          packet_subformat_o,
  output logic [8*MAX_BYTES-1:0]   payload_o,
  output logic [TRDB_LEN_W-1:0]    length_o,
  output logic [4:0]               branches_o,
  output logic                     err_o
);

  localparam int unsigned PW = 8 * MAX_BYTES;
  localparam logic [TRDB_LEN_W-1:0] LEN_ONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_OUTPUT
  } state_e;

  state_e                  state_q, state_d;
  logic [TRDB_LEN_W-1:0]   len_q, len_d;
  logic [TRDB_LEN_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]           payload_q, payload_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic                    byte_xfer;
  trdb_format_e            fmt;

  assign ready_o   = (state_q != ST_OUTPUT);
  assign byte_xfer = valid_i && ready_o;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (byte_xfer) begin
          if ((data_i != 8'd0) && (32'(data_i) <= MAX_BYTES)) begin
            len_d     = data_i[TRDB_LEN_W-1:0];
            cnt_d     = '0;
            payload_d = '0;
            state_d   = ST_COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (byte_xfer) begin
          for (int k = 0; k < int'(MAX_BYTES); k++) begin
            if (cnt_q == k[TRDB_LEN_W-1:0]) payload_d[8*k +: 8] = data_i;
          end
          cnt_d = cnt_q + LEN_ONE;
          if (cnt_q == (len_q - LEN_ONE)) begin
            state_d = ST_OUTPUT;
            valid_d = 1'b1;
          end
        end
      end
      ST_OUTPUT: begin
        if (packet_ready_i) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      payload_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // Header fields are decoded straight from the stored payload; they only mean something while valid.
  assign fmt                = trdb_format_e'(payload_q[1:0]);
  assign packet_format_o    = fmt;
  assign packet_subformat_o = (fmt == TRDB_FMT3) ? trdb_subformat_e'(payload_q[3:2]) : TRDB_SUB0;
  assign payload_o          = (fmt == TRDB_FMT3) ? (payload_q >> 4) : (payload_q >> 2);
  assign branches_o         = (fmt == TRDB_FMT1) ? payload_q[6:2] : 5'd0;
  assign length_o           = len_q;
  assign packet_valid_o     = valid_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_trdb_packet_decoder.sv
// Directed bench for trdb_packet_decoder with an expected-packet queue checked by a monitor.
module tb_trdb_packet_decoder;
  import trdb_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic [7:0]     data_i = 8'd0;
  logic           valid_i = 1'b0;
  logic           ready_o;
  logic           packet_valid_o;
  logic           packet_ready_i = 1'b1;
  trdb_format_e   packet_format_o;
  trdb_subformat_e packet_subformat_o;
  logic [255:0]   payload_o;
  logic [5:0]     length_o;
  logic [4:0]     branches_o;
  logic           err_o;

  trdb_packet_decoder #(.MAX_BYTES(32)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .data_i             (data_i),
    .valid_i            (valid_i),
    .ready_o            (ready_o),
    .packet_valid_o     (packet_valid_o),
    .packet_ready_i     (packet_ready_i),
    .packet_format_o    (packet_format_o),
    .packet_subformat_o (packet_subformat_o),
    .payload_o          (payload_o),
    .length_o           (length_o),
    .branches_o         (branches_o),
    .err_o              (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]   fmt;
    logic [1:0]   sub;
    logic [255:0] pl;
    logic [5:0]   len;
    logic [4:0]   br;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       last_exp;
  logic [7:0] pbuf [32];
  int         vectors = 0;
  int         miscompares = 0;
  int         err_cycles = 0;
  int         pkts_seen = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode of the bytes in pbuf, straight from the framing definition.
  function automatic exp_t model(input int n);
    exp_t e;
    logic [255:0] raw;
    raw = '0;
    for (int k = 0; k < n; k++) raw[8*k +: 8] = pbuf[k];
    e.fmt = raw[1:0];
    e.sub = (e.fmt == 2'd3) ? raw[3:2] : 2'd0;
    e.pl  = (e.fmt == 2'd3) ? (raw >> 4) : (raw >> 2);
    e.len = 6'(n);
    e.br  = (e.fmt == 2'd1) ? raw[6:2] : 5'd0;
    return e;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    valid_i = 1'b1;
    data_i  = b;
    while (!ready_o && t < 50) begin
      @(posedge clk_i); #1;
      t++;
    end
    chk("ready_wait_timeout", 256'(ready_o), 256'(1));
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic send_packet(input int n, input int gap, input exp_t e);
    exp_q.push_back(e);
    last_exp = e;
    send_byte(8'(n));
    for (int k = 0; k < n; k++) begin
      if (gap > 0) idle($urandom_range(0, gap));
      send_byte(pbuf[k]);
    end
  endtask

  always @(negedge clk_i) begin
    if (err_o) err_cycles++;
    if (rst_ni && packet_valid_o && packet_ready_i) begin
      pkts_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_packet", 256'(1), 256'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pkt_format", 256'(packet_format_o), 256'(e.fmt));
        chk("pkt_subformat", 256'(packet_subformat_o), 256'(e.sub));
        chk("pkt_payload", payload_o, e.pl);
        chk("pkt_length", 256'(length_o), 256'(e.len));
        chk("pkt_branches", 256'(branches_o), 256'(e.br));
      end
    end
  end

  initial begin
    exp_t e;
    int err_before, pkts_before;

    // Reset state
    idle(3);
    rst_ni = 1'b1;
    chk("rst_ready", 256'(ready_o), 256'(1));
    chk("rst_pkt_valid", 256'(packet_valid_o), 256'(0));
    chk("rst_err", 256'(err_o), 256'(0));
    chk("rst_format", 256'(packet_format_o), 256'(0));
    chk("rst_subformat", 256'(packet_subformat_o), 256'(0));
    chk("rst_payload", payload_o, 256'(0));
    chk("rst_length", 256'(length_o), 256'(0));
    chk("rst_branches", 256'(branches_o), 256'(0));

    // 0x02,0x05,0x03 -> format 1, branches 1, payload 0xC1
    pbuf[0] = 8'h05; pbuf[1] = 8'h03;
    e.fmt = 2'd1; e.sub = 2'd0; e.pl = 256'h00C1; e.len = 6'd2; e.br = 5'd1;
    send_packet(2, 0, e);

    // 0x01,0x07 -> format 3, subformat 1, payload 0
    pbuf[0] = 8'h07;
    e.fmt = 2'd3; e.sub = 2'd1; e.pl = 256'h0; e.len = 6'd1; e.br = 5'd0;
    send_packet(1, 0, e);
    idle(3);

    // Illegal lengths 0 and 33, back to back
    err_before  = err_cycles;
    pkts_before = pkts_seen;
    send_byte(8'h00);
    chk("err_pulse_len0", 256'(err_o), 256'(1));
    send_byte(8'h21);
    chk("err_pulse_len33", 256'(err_o), 256'(1));
    chk("err_ready", 256'(ready_o), 256'(1));
    idle(1);
    chk("err_clears", 256'(err_o), 256'(0));
    idle(2);
    chk("err_cycle_count", 256'(err_cycles - err_before), 256'(2));
    chk("err_no_packet", 256'(pkts_seen - pkts_before), 256'(0));
    chk("err_ready_after", 256'(ready_o), 256'(1));

    // Back-pressure: hold packet 5 cycles
    packet_ready_i = 1'b0;
    pbuf[0] = 8'h09; pbuf[1] = 8'hAA; pbuf[2] = 8'h55;
    send_packet(3, 0, model(3));
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 256'(packet_valid_o), 256'(1));
      chk("hold_ready", 256'(ready_o), 256'(0));
      chk("hold_payload", payload_o, last_exp.pl);
      chk("hold_branches", 256'(branches_o), 256'(last_exp.br));
      idle(1);
    end
    packet_ready_i = 1'b1;
    idle(1);
    chk("release_valid", 256'(packet_valid_o), 256'(0));
    chk("release_ready", 256'(ready_o), 256'(1));

    // Reset mid-packet after 2 of 4 payload bytes
    pkts_before = pkts_seen;
    err_before  = err_cycles;
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_ni = 1'b0;
    idle(1);
    rst_ni = 1'b1;
    chk("midrst_ready", 256'(ready_o), 256'(1));
    chk("midrst_valid", 256'(packet_valid_o), 256'(0));
    chk("midrst_length", 256'(length_o), 256'(0));
    chk("midrst_payload", payload_o, 256'(0));
    pbuf[0] = 8'h00;
    e.fmt = 2'd0; e.sub = 2'd0; e.pl = 256'h0; e.len = 6'd1; e.br = 5'd0;
    send_packet(1, 0, e);
    idle(3);
    chk("midrst_one_packet", 256'(pkts_seen - pkts_before), 256'(1));
    chk("midrst_no_err", 256'(err_cycles - err_before), 256'(0));

    // Full-size packets: random gaps, then format 3 without gaps
    for (int k = 0; k < 32; k++) pbuf[k] = 8'($urandom);
    send_packet(32, 3, model(32));
    for (int k = 0; k < 32; k++) pbuf[k] = 8'($urandom);
    pbuf[0] = 8'hBF;
    send_packet(32, 0, model(32));
    for (int k = 0; k < 7; k++) pbuf[k] = 8'($urandom);
    pbuf[0] = 8'h7D;
    send_packet(7, 2, model(7));

    for (int t = 0; t < 200 && exp_q.size() != 0; t++) idle(1);
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    chk("total_packets", 256'(pkts_seen), 256'(7));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
